// File: rtl/period_meter_if.sv
// period_meter_if: signal-in / result-out bundle for period_meter.
// Optional DUTY_MEAS_EN adds the high_time result field.
// slave = meter side, master = driver/consumer side.
interface period_meter_if #(
  parameter int CNT_W = 26
);
  logic             sig_in;
  logic             meas_en;
  logic             ack;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             overrun;
  logic             stale;
`ifdef DUTY_MEAS_EN
  logic [CNT_W-1:0] high_time;

  modport master (output sig_in, meas_en, ack,
                  input  period, valid, overrun, stale, high_time);
  modport slave  (input  sig_in, meas_en, ack,
                  output period, valid, overrun, stale, high_time);
`else
  modport master (output sig_in, meas_en, ack,
                  input  period, valid, overrun, stale);
  modport slave  (input  sig_in, meas_en, ack,
                  output period, valid, overrun, stale);
`endif
endinterface

// File: rtl/period_meter.sv
// period_meter: counts clk cycles between rising edges of an async slow signal.
// Latency: sig_in rise to valid = SYNC_STAGES+2 edges; valid holds until ack.
// Backpressure: an unacked result is overwritten and sets sticky overrun.
// Optional build macro DUTY_MEAS_EN adds high-phase measurement (high_time).
module period_meter #(
  parameter int CNT_W       = 26,
  parameter int TIMEOUT     = 50_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  period_meter_if.slave bus
);

  // Reject configurations the counter or synchronizer cannot support.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("period_meter: SYNC_STAGES must be >= 2");
  end
  if (64'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_width
    $error("period_meter: TIMEOUT does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_MEAS} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_dly_q, s_dly_d;
  logic                   rise_q, rise_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;
  logic                   stale_q, stale_d;
  logic                   capture;
`ifdef DUTY_MEAS_EN
  logic                   fall_q, fall_d;
  logic                   fall_seen_q, fall_seen_d;
  logic [CNT_W-1:0]       hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0]       high_time_q, high_time_d;
`endif

  // Synchronizer, edge detect, measurement FSM and result handshake.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], bus.sig_in};
    s_dly_d   = sync_q[SYNC_STAGES-1];
    // Registered edge pulse keeps the edge-to-valid latency fixed.
    rise_d    = sync_q[SYNC_STAGES-1] & ~s_dly_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    stale_d   = stale_q;
    capture   = 1'b0;
`ifdef DUTY_MEAS_EN
    fall_d      = ~sync_q[SYNC_STAGES-1] & s_dly_q;
    fall_seen_d = fall_seen_q;
    hi_cnt_d    = hi_cnt_q;
    high_time_d = high_time_q;
`endif
    if (!bus.meas_en) begin
      // Disable clears the session but keeps the last reported period.
      state_d   = ST_IDLE;
      cnt_d     = '0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
      stale_d   = 1'b0;
`ifdef DUTY_MEAS_EN
      fall_seen_d = 1'b0;
      hi_cnt_d    = '0;
`endif
    end else begin
      if (bus.ack) valid_d = 1'b0;
      case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM: begin
          // First edge only starts the count; there is no prior edge to measure from.
          if (rise_q) begin
            state_d = ST_MEAS;
            cnt_d   = ONE_C;
`ifdef DUTY_MEAS_EN
            fall_seen_d = 1'b0;
`endif
          end
        end
        ST_MEAS: begin
          cnt_d = cnt_q + ONE_C;
          if (rise_q) begin
            capture = 1'b1;
            cnt_d   = ONE_C;
          end else if (cnt_q == TIMEOUT_C) begin
            stale_d = 1'b1;
            cnt_d   = '0;
            state_d = ST_ARM;
          end
`ifdef DUTY_MEAS_EN
          if (fall_q) begin
            hi_cnt_d    = cnt_q;
            fall_seen_d = 1'b1;
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
      if (capture) begin
        period_d = cnt_q;
        valid_d  = 1'b1;
        stale_d  = 1'b0;
        // Same-cycle ack consumes the old result, so it is not an overrun.
        if (valid_q && !bus.ack) overrun_d = 1'b1;
`ifdef DUTY_MEAS_EN
        // Without a fall the signal stayed high the whole period.
        high_time_d = fall_seen_q ? hi_cnt_q : cnt_q;
        fall_seen_d = 1'b0;
`endif
      end
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sync_q    <= '0;
      s_dly_q   <= 1'b0;
      rise_q    <= 1'b0;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      stale_q   <= 1'b0;
`ifdef DUTY_MEAS_EN
      fall_q      <= 1'b0;
      fall_seen_q <= 1'b0;
      hi_cnt_q    <= '0;
      high_time_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      s_dly_q   <= s_dly_d;
      rise_q    <= rise_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      stale_q   <= stale_d;
`ifdef DUTY_MEAS_EN
      fall_q      <= fall_d;
      fall_seen_q <= fall_seen_d;
      hi_cnt_q    <= hi_cnt_d;
      high_time_q <= high_time_d;
`endif
    end
  end

  assign bus.period  = period_q;
  assign bus.valid   = valid_q;
  assign bus.overrun = overrun_q;
  assign bus.stale   = stale_q;
`ifdef DUTY_MEAS_EN
  assign bus.high_time = high_time_q;
`endif

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed scoreboard bench for period_meter (CNT_W=8, TIMEOUT=100).
// Expected periods are queued when a measuring edge is driven and checked at the
// cycle the result must appear.
module tb_period_meter;
  localparam int CNT_W = 8;
  localparam int TMO   = 100;
  localparam int SYNC  = 2;
  localparam int LAT   = SYNC + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  period_meter_if #(.CNT_W(CNT_W)) bus();

  period_meter #(.CNT_W(CNT_W), .TIMEOUT(TMO), .SYNC_STAGES(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int age = 1000;
  int ph = 0;
  int hi_len = 5;
  int lo_len = 5;
  int ack_mode = 0;   // 0 = driven manually, 1 = always 1, 2 = only on capture edge
  bit wave_on = 1'b0;
  bit armed = 1'b0;
  bit pend = 1'b0;
  bit rise_now = 1'b0;
  int exp_p[$];
  int exp_h[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs 1 time unit after the edge, then drive next inputs.
  task automatic step();
    int e;
    @(posedge clk);
    #1;
    age++;
    rise_now = 1'b0;
    if (pend && age == LAT - 1 && ack_mode == 1) check("lat_early", bus.valid, 1'b0);
    if (pend && age == LAT) begin
      check("lat_valid", bus.valid, 1'b1);
      if (exp_p.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_empty observed=%0d expected=nonempty", exp_p.size());
      end else begin
        e = exp_p.pop_front();
        check("period", bus.period, e);
        e = exp_h.pop_front();
`ifdef DUTY_MEAS_EN
        check("high_time", bus.high_time, e);
`endif
      end
      pend = 1'b0;
    end
    if (ack_mode == 1) bus.ack = 1'b1;
    if (ack_mode == 2) bus.ack = (age == LAT - 1);
    if (wave_on) begin
      ph = (ph + 1) % (hi_len + lo_len);
      if (ph == 0) begin
        age = 0;
        rise_now = 1'b1;
        if (armed) begin
          exp_p.push_back(hi_len + lo_len);
          exp_h.push_back(hi_len);
          pend = 1'b1;
        end else begin
          armed = 1'b1;
        end
      end
      bus.sig_in = (ph < hi_len);
    end
  endtask

  // Drive n rising edges of a hi/lo square wave, then finish the last period low.
  task automatic run_rises(input int n, input int hi, input int lo);
    int seen;
    seen = 0;
    hi_len = hi;
    lo_len = lo;
    ph = hi + lo - 1;
    bus.sig_in = 1'b0;
    wave_on = 1'b1;
    while (seen < n) begin
      step();
      if (rise_now) seen++;
    end
    repeat (hi + lo - 1) step();
    wave_on = 1'b0;
    bus.sig_in = 1'b0;
  endtask

  task automatic restart();
    bus.meas_en = 1'b0;
    step();
    step();
    bus.meas_en = 1'b1;
    armed = 1'b0;
    step();
  endtask

  initial begin
    bus.sig_in = 1'b0;
    bus.meas_en = 1'b0;
    bus.ack = 1'b0;

    // Reset state.
    step();
    check("rst_valid", bus.valid, 1'b0);
    check("rst_period", bus.period, 0);
    check("rst_overrun", bus.overrun, 1'b0);
    check("rst_stale", bus.stale, 1'b0);
`ifdef DUTY_MEAS_EN
    check("rst_high_time", bus.high_time, 0);
`endif
    rst = 1'b0;
    bus.meas_en = 1'b1;
    step();

    // 1+2: period 10, ack tied high, exact edge-to-valid latency.
    ack_mode = 1;
    run_rises(6, 5, 5);
    check("t1_overrun", bus.overrun, 1'b0);
    check("t1_valid_acked", bus.valid, 1'b0);

    // 3: no ack, period 8, three edges -> overrun.
    ack_mode = 0;
    bus.ack = 1'b0;
    restart();
    run_rises(3, 4, 4);
    check("t3_valid", bus.valid, 1'b1);
    check("t3_overrun", bus.overrun, 1'b1);
    check("t3_period", bus.period, 8);
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    check("t3_ack_valid", bus.valid, 1'b0);
    check("t3_ack_overrun", bus.overrun, 1'b1);
    step();
    check("t3_ack_ignored", bus.valid, 1'b0);

    // 4: timeout after the last edge, then recovery.
    ack_mode = 1;
    restart();
    check("t4_disable_clears", bus.overrun, 1'b0);
    run_rises(2, 5, 5);
    while (age < LAT + TMO - 1) step();
    check("t4_stale_early", bus.stale, 1'b0);
    step();
    check("t4_stale_set", bus.stale, 1'b1);
    armed = 1'b0;
    run_rises(1, 5, 5);
    check("t4_stale_after_arm", bus.stale, 1'b1);
    run_rises(1, 5, 5);
    check("t4_stale_cleared", bus.stale, 1'b0);

    // 5: ack coincident with capture, period 12.
    ack_mode = 0;
    bus.ack = 1'b0;
    restart();
    run_rises(2, 6, 6);
    check("t5_valid_pre", bus.valid, 1'b1);
    ack_mode = 2;
    run_rises(1, 6, 6);
    check("t5_valid", bus.valid, 1'b1);
    check("t5_period", bus.period, 12);
    check("t5_overrun", bus.overrun, 1'b0);

    // 6a: reset mid-measurement.
    ack_mode = 0;
    bus.ack = 1'b0;
    restart();
    run_rises(2, 5, 5);
    check("t6_valid_pre", bus.valid, 1'b1);
    rst = 1'b1;
    step();
    check("t6_rst_valid", bus.valid, 1'b0);
    check("t6_rst_period", bus.period, 0);
    rst = 1'b0;
    armed = 1'b0;
    step();
    run_rises(1, 5, 5);
    check("t6_rst_first_edge", bus.valid, 1'b0);
    run_rises(1, 5, 5);
    check("t6_rst_second_edge", bus.valid, 1'b1);

    // 6b: meas_en low mid-measurement.
    run_rises(2, 5, 5);
    check("t6_overrun_pre", bus.overrun, 1'b1);
    bus.meas_en = 1'b0;
    step();
    step();
    check("t6_dis_valid", bus.valid, 1'b0);
    check("t6_dis_overrun", bus.overrun, 1'b0);
    check("t6_dis_stale", bus.stale, 1'b0);
    check("t6_dis_period_kept", bus.period, 10);
    bus.meas_en = 1'b1;
    armed = 1'b0;
    step();
    run_rises(1, 5, 5);
    check("t6_en_first_edge", bus.valid, 1'b0);
    run_rises(1, 5, 5);
    check("t6_en_second_edge", bus.valid, 1'b1);

    if (exp_p.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", exp_p.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
